// File: rtl/display_scan_ctrl.sv
// Round-robin scanner for an 8-digit common-anode 7-segment display.
// Latches one frame of inputs at digit 0, with per-slot blanking and 3-bit PWM dimming.
module display_scan_ctrl #(
  parameter int unsigned TICKS_PER_DIGIT = 100000,
  parameter int unsigned BLANK_TICKS     = 8,
  parameter int unsigned N_DIGITS        = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] value,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp,
  input  logic [2:0]  brightness,
  output logic [6:0]  segments,
  output logic        dp_n,
  output logic [7:0]  anodos,
  output logic        frame_start
);

  localparam int unsigned CW = $clog2(TICKS_PER_DIGIT);
  localparam int unsigned IW = $clog2(N_DIGITS);
  localparam int unsigned D  = TICKS_PER_DIGIT - BLANK_TICKS;

  localparam logic [CW-1:0] LAST_TICK  = CW'(TICKS_PER_DIGIT - 1);
  localparam logic [CW-1:0] LAST_BLANK = CW'(BLANK_TICKS - 1);
  localparam logic [CW-1:0] BLANK_W    = CW'(BLANK_TICKS);
  localparam logic [IW-1:0] LAST_IDX   = IW'(N_DIGITS - 1);
  localparam logic [CW+2:0] D_W        = (CW+3)'(D);

  typedef enum logic [1:0] {RST_IDLE, BLANK, DRIVE} state_t;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            latch;

  logic [31:0]     value_sh;
  logic [7:0]      en_sh;
  logic [7:0]      dp_sh;
  logic [2:0]      bright_sh;

  logic [CW+2:0]   on_len;
  logic [CW-1:0]   pos;
  logic [7:0]      anodos_n;
  logic [6:0]      segments_n;
  logic            dp_n_n;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // cnt runs across the whole slot (blank + drive), so the drive position is cnt - BLANK_TICKS
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt + 1'b1;
    latch   = 1'b0;
    unique case (state)
      RST_IDLE: begin
        state_n = BLANK;
        idx_n   = '0;
        cnt_n   = '0;
        latch   = 1'b1;
      end
      BLANK: begin
        if (cnt == LAST_BLANK) state_n = DRIVE;
      end
      DRIVE: begin
        if (cnt == LAST_TICK) begin
          state_n = BLANK;
          cnt_n   = '0;
          latch   = (idx == LAST_IDX);
          idx_n   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
      end
      default: state_n = RST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they land on the same edge as the counters
  always_comb begin
    on_len     = (((CW+3)'(bright_sh) + (CW+3)'(1)) * D_W) >> 3;
    pos        = cnt_n - BLANK_W;
    anodos_n   = '1;
    segments_n = '1;
    dp_n_n     = 1'b1;
    if ((state_n == DRIVE) && en_sh[idx_n] && ((CW+3)'(pos) < on_len)) begin
      anodos_n   = ~(8'b1 << idx_n);
      segments_n = hex7(value_sh[{idx_n, 2'b00} +: 4]);
      dp_n_n     = ~dp_sh[idx_n];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RST_IDLE;
      idx         <= '0;
      cnt         <= '0;
      value_sh    <= '0;
      en_sh       <= '0;
      dp_sh       <= '0;
      bright_sh   <= '0;
      anodos      <= '1;
      segments    <= '1;
      dp_n        <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      anodos      <= anodos_n;
      segments    <= segments_n;
      dp_n        <= dp_n_n;
      frame_start <= latch;
      if (latch) begin
        value_sh  <= value;
        en_sh     <= digit_en;
        dp_sh     <= dp;
        bright_sh <= brightness;
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl: a frame-level timing model predicts each cycle's
// display outputs, and a negedge monitor compares them against the DUT.
module tb_display_scan_ctrl;

  localparam int unsigned T = 16;
  localparam int unsigned B = 2;
  localparam int unsigned FRAME = 8 * T;

  logic        clock;
  logic        reset;
  logic [31:0] value;
  logic [7:0]  digit_en;
  logic [7:0]  dp;
  logic [2:0]  brightness;
  logic [6:0]  segments;
  logic        dp_n;
  logic [7:0]  anodos;
  logic        frame_start;

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dpn;
    logic       fs;
  } obs_t;

  obs_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference model state
  bit          running = 0;
  int unsigned mt = 0;
  logic [31:0] m_val;
  logic [7:0]  m_en;
  logic [7:0]  m_dp;
  logic [2:0]  m_br;
  logic [6:0]  hex_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  display_scan_ctrl #(
    .TICKS_PER_DIGIT(T),
    .BLANK_TICKS(B),
    .N_DIGITS(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .value(value),
    .digit_en(digit_en),
    .dp(dp),
    .brightness(brightness),
    .segments(segments),
    .dp_n(dp_n),
    .anodos(anodos),
    .frame_start(frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: t counts cycles since the first edge after reset release; frame, slot and
  // position within the slot follow by division.
  always @(posedge clock) begin
    obs_t        e;
    int unsigned slot;
    int unsigned pos;
    int unsigned on;
    e = '{an: 8'hFF, seg: 7'h7F, dpn: 1'b1, fs: 1'b0};
    if (!reset) begin
      running = 0;
    end else begin
      if (!running) begin
        running = 1;
        mt = 0;
      end else begin
        mt++;
      end
      if (mt % FRAME == 0) begin
        m_val = value;
        m_en  = digit_en;
        m_dp  = dp;
        m_br  = brightness;
        e.fs  = 1'b1;
      end
      slot = (mt / T) % 8;
      pos  = mt % T;
      on   = ((int'(m_br) + 1) * (T - B)) / 8;
      if (pos >= B && (pos - B) < on && m_en[slot]) begin
        e.an  = ~(8'd1 << slot);
        e.seg = hex_tab[(m_val >> (4 * slot)) & 32'hF];
        e.dpn = ~m_dp[slot];
      end
    end
    exp_q.push_back(e);
  end

  always @(negedge clock) begin
    obs_t a;
    obs_t e;
    a = {anodos, segments, dp_n, frame_start};
    checks++;
    assert ($countones(~anodos) <= 1) else begin
      errors++;
      $display("FAIL onehot t=%0t anodos=%b (at most one low bit required)", $time, anodos);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL scan t=%0t mt=%0d got an=%h seg=%b dpn=%b fs=%b required an=%h seg=%b dpn=%b fs=%b",
                 $time, mt, a.an, a.seg, a.dpn, a.fs, e.an, e.seg, e.dpn, e.fs);
      end
    end
  end

  task automatic check_reset_outputs(input string name);
    checks++;
    if (anodos !== 8'hFF || segments !== 7'h7F || dp_n !== 1'b1 || frame_start !== 1'b0) begin
      errors++;
      $display("FAIL %s got an=%h seg=%b dpn=%b fs=%b required an=ff seg=1111111 dpn=1 fs=0",
               name, anodos, segments, dp_n, frame_start);
    end
  endtask

  task automatic wait_slot(input int unsigned s, input int unsigned p);
    int unsigned n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(running && ((mt / T) % 8 == s) && (mt % T == p)) && n < 3000);
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL wait_slot timeout slot=%0d pos=%0d", s, p);
    end
  endtask

  initial begin
    reset      = 1'b1;
    value      = '0;
    digit_en   = '0;
    dp         = '0;
    brightness = '0;
    #1 reset = 1'b0;
    #1 check_reset_outputs("rst_init");

    // basic scan
    repeat (3) @(negedge clock);
    value      = 32'h76543210;
    digit_en   = 8'hFF;
    brightness = 3'd7;
    #2 reset = 1'b1;
    repeat (2 * FRAME + 4) @(negedge clock);

    // brightness levels
    brightness = 3'd3;
    repeat (2 * FRAME) @(negedge clock);
    brightness = 3'd0;
    repeat (2 * FRAME) @(negedge clock);

    // enable mask and decimal point
    digit_en   = 8'h0F;
    dp         = 8'h01;
    value      = 32'hFFFFABCD;
    brightness = 3'd7;
    repeat (2 * FRAME) @(negedge clock);

    // mid-frame value change must not tear
    value    = 32'h0;
    digit_en = 8'hFF;
    dp       = 8'h00;
    wait_slot(7, 0);
    wait_slot(3, 5);
    value = 32'h88888888;
    wait_slot(0, 1);
    repeat (FRAME) @(negedge clock);

    // asynchronous reset during digit 5 on-phase
    wait_slot(5, 4);
    #2 reset = 1'b0;
    #1 check_reset_outputs("rst_mid");
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    repeat (FRAME + 2) @(negedge clock);

    // randomized inputs over 10 frames
    for (int i = 0; i < 10 * int'(FRAME); i++) begin
      @(negedge clock);
      if ($urandom_range(0, 15) == 0) begin
        value      = $urandom;
        digit_en   = 8'($urandom);
        dp         = 8'($urandom);
        brightness = 3'($urandom_range(0, 7));
      end
    end
    repeat (2) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
